// File: rtl/stall_unit_pkg.sv
// ============================================================================
// Module      : stall_unit_pkg
// Description : Shared result-source codes, Tuse encodings and Tnew lookup
//               for the stall unit and the forwarding logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stall_unit_pkg;

    // Result-source codes, shared bit-for-bit with the forwarding unit
    typedef enum logic [2:0] {
        RES_NW   = 3'd0,
        RES_ALU  = 3'd1,
        RES_DM   = 3'd2,
        RES_PC   = 3'd3,
        RES_MOVZ = 3'd4
    } res_e;

    localparam logic [1:0] c_tuse_d      = 2'd0;
    localparam logic [1:0] c_tuse_e      = 2'd1;
    localparam logic [1:0] c_tuse_m      = 2'd2;
    localparam logic [1:0] c_tuse_unused = 2'd3;

    localparam logic [4:0] c_epc_idx = 5'd14;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // Cycles until the E-stage instruction produces its result
    function automatic logic [1:0] tnew_e(input logic [2:0] res);
        logic [1:0] t;
        t = 2'd0;
        case (res_e'(res))
            RES_ALU, RES_MOVZ: t = 2'd1;
            RES_DM:            t = 2'd2;
            default:           t = 2'd0;
        endcase
        return t;
    endfunction

    // Only a load is still in flight once it reaches M
    function automatic logic [1:0] tnew_m(input logic [2:0] res);
        logic [1:0] t;
        t = 2'd0;
        if (res_e'(res) == RES_DM) begin
            t = 2'd1;
        end
        return t;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stall_unit_if.sv
// ============================================================================
// Module      : stall_unit_if
// Description : Pipeline-side hazard bus between the MIPS datapath and the
//               stall unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stall_unit_if #(
    parameter int CNT_W = 4
);
    logic [4:0]       rs_D;
    logic [4:0]       rt_D;
    logic [1:0]       tuse_rs_D;
    logic [1:0]       tuse_rt_D;
    logic [4:0]       A3_E;
    logic [4:0]       A3_M;
    logic [2:0]       Res_E;
    logic [2:0]       Res_M;
    logic             md_use_D;
    logic             md_start_E;
    logic             md_div_E;
    logic             eret_D;
    logic             epc_wr_E;
    logic             exc_flush;
    logic             stall;
    logic             flush_E;
    logic             md_busy;
    logic [CNT_W-1:0] md_count;
    logic [31:0]      stall_cnt;

    // Pipeline side: supplies stage information, consumes the stall controls
    modport master (
        output rs_D, rt_D, tuse_rs_D, tuse_rt_D, A3_E, A3_M, Res_E, Res_M,
        output md_use_D, md_start_E, md_div_E, eret_D, epc_wr_E, exc_flush,
        input  stall, flush_E, md_busy, md_count, stall_cnt
    );

    modport slave (
        input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, A3_E, A3_M, Res_E, Res_M,
        input  md_use_D, md_start_E, md_div_E, eret_D, epc_wr_E, exc_flush,
        output stall, flush_E, md_busy, md_count, stall_cnt
    );
endinterface

`default_nettype wire

// File: rtl/stall_unit_md_busy_ctr.sv
// ============================================================================
// Module      : md_busy_ctr
// Description : IDLE/BUSY tracker and countdown for the multi-cycle HI/LO
//               mult/div unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_busy_ctr
    import stall_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             md_start_E,
    input  wire logic             md_div_E,
    input  wire logic             exc_flush,
    output logic                  md_busy,
    output logic [CNT_W-1:0]      md_count
);

    localparam logic [CNT_W-1:0] c_mult_load = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] c_div_load  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

    md_state_e        r_state;
    md_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= MD_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            MD_IDLE: begin
                // A flushed mult/div never reaches HI/LO, so it never loads
                if (md_start_E && !exc_flush) begin
                    w_state_nxt = MD_BUSY;
                    w_count_nxt = md_div_E ? c_div_load : c_mult_load;
                end
            end
            MD_BUSY: begin
                // Runs to completion regardless of exc_flush; a stray start is ignored
                if (r_count <= c_one) begin
                    w_state_nxt = MD_IDLE;
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = r_count - c_one;
                end
            end
            default: begin
                w_state_nxt = MD_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    assign md_busy  = (r_state == MD_BUSY);
    assign md_count = r_count;

endmodule

`default_nettype wire

// File: rtl/stall_unit.sv
// ============================================================================
// Module      : stall_unit
// Description : Hazard detection for the 5-stage MIPS core; freezes PC/IF-ID
//               and bubbles ID/EX wherever forwarding cannot cover a hazard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stall_unit
    import stall_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  wire logic    clk,
    input  wire logic    reset_n,
    stall_unit_if.slave  bus
);

    logic [4:0]       w_src  [2];
    logic [1:0]       w_tuse [2];
    logic [1:0]       w_reg_haz;
    logic [1:0]       w_tnew_e;
    logic [1:0]       w_tnew_m;
    logic             w_md_busy;
    logic [CNT_W-1:0] w_md_count;
    logic             w_md_haz;
    logic             w_epc_haz;
    logic             w_stall;
    logic [31:0]      r_stall_cnt;

    md_busy_ctr #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_ctr (
        .clk        (clk),
        .reset_n    (reset_n),
        .md_start_E (bus.md_start_E),
        .md_div_E   (bus.md_div_E),
        .exc_flush  (bus.exc_flush),
        .md_busy    (w_md_busy),
        .md_count   (w_md_count)
    );

    assign w_tnew_e  = tnew_e(bus.Res_E);
    assign w_tnew_m  = tnew_m(bus.Res_M);

    assign w_src[0]  = bus.rs_D;
    assign w_src[1]  = bus.rt_D;
    assign w_tuse[0] = bus.tuse_rs_D;
    assign w_tuse[1] = bus.tuse_rt_D;

    // Stall only when the producer is later than the consumer; Tnew=0 is forwarded
    for (genvar i = 0; i < 2; i++) begin : g_operand
        assign w_reg_haz[i] = (w_src[i] != 5'd0) &&
                              (((bus.A3_E == w_src[i]) && (w_tnew_e > w_tuse[i])) ||
                               ((bus.A3_M == w_src[i]) && (w_tnew_m > w_tuse[i])));
    end

    assign w_md_haz  = bus.md_use_D && (w_md_busy || bus.md_start_E);
    assign w_epc_haz = bus.eret_D && bus.epc_wr_E;

    // The CP0 flush owns the pipeline, and reset keeps the pipeline moving
    assign w_stall = reset_n && !bus.exc_flush &&
                     ((|w_reg_haz) || w_md_haz || w_epc_haz);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stall_cnt <= 32'd0;
        end else if (w_stall) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.stall     = w_stall;
    assign bus.flush_E   = w_stall;
    assign bus.md_busy   = w_md_busy;
    assign bus.md_count  = w_md_count;
    assign bus.stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_stall_unit.sv
// ============================================================================
// Module      : tb_stall_unit
// Description : Scoreboard bench for stall_unit: directed hazard scenarios
//               followed by randomized pipeline traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stall_unit;

    typedef struct {
        logic       reset_n;
        logic [4:0] rs_D, rt_D, A3_E, A3_M;
        logic [1:0] tuse_rs_D, tuse_rt_D;
        logic [2:0] Res_E, Res_M;
        logic       md_use_D, md_start_E, md_div_E;
        logic       eret_D, epc_wr_E, exc_flush;
    } stim_t;

    typedef struct {
        logic        stall;
        logic        busy;
        logic [3:0]  count;
        logic [31:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;

    stall_unit_if #(.CNT_W(4)) bus ();

    stall_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int    tests = 0;
    int    fails = 0;
    exp_t  exp_q[$];
    stim_t cur, nx;
    int    m_rem = 0;
    bit [31:0] m_cnt = 0;
    logic  last_stall = 1'b0;

    // Reference: Tnew in E indexed by result code (NW, ALU, DM, PC, MOVZ)
    int tnew_e_tab[8] = '{0, 1, 2, 0, 1, 0, 0, 0};

    function automatic logic ref_reg_haz(logic [4:0] src, logic [1:0] tuse, stim_t s);
        int te, tm;
        te = tnew_e_tab[s.Res_E];
        tm = (s.Res_M == 3'd2) ? 1 : 0;
        if (src == 0) return 1'b0;
        return ((s.A3_E == src) && (te > int'(tuse))) || ((s.A3_M == src) && (tm > int'(tuse)));
    endfunction

    function automatic logic ref_stall(stim_t s, int rem);
        logic h;
        if (!s.reset_n || s.exc_flush) return 1'b0;
        h = ref_reg_haz(s.rs_D, s.tuse_rs_D, s) || ref_reg_haz(s.rt_D, s.tuse_rt_D, s);
        h = h || (s.md_use_D && ((rem > 0) || s.md_start_E));
        h = h || (s.eret_D && s.epc_wr_E);
        return h;
    endfunction

    task automatic apply(stim_t s);
        reset_n        = s.reset_n;
        bus.rs_D       = s.rs_D;
        bus.rt_D       = s.rt_D;
        bus.tuse_rs_D  = s.tuse_rs_D;
        bus.tuse_rt_D  = s.tuse_rt_D;
        bus.A3_E       = s.A3_E;
        bus.A3_M       = s.A3_M;
        bus.Res_E      = s.Res_E;
        bus.Res_M      = s.Res_M;
        bus.md_use_D   = s.md_use_D;
        bus.md_start_E = s.md_start_E;
        bus.md_div_E   = s.md_div_E;
        bus.eret_D     = s.eret_D;
        bus.epc_wr_E   = s.epc_wr_E;
        bus.exc_flush  = s.exc_flush;
    endtask

    function automatic stim_t quiet();
        stim_t s;
        s = '{reset_n: 1'b1, rs_D: 5'd0, rt_D: 5'd0, A3_E: 5'd0, A3_M: 5'd0,
              tuse_rs_D: 2'd3, tuse_rt_D: 2'd3, Res_E: 3'd0, Res_M: 3'd0,
              md_use_D: 1'b0, md_start_E: 1'b0, md_div_E: 1'b0,
              eret_D: 1'b0, epc_wr_E: 1'b0, exc_flush: 1'b0};
        return s;
    endfunction

    // Advance one clock: retire the previous cycle into the model, then drive nx
    task automatic step();
        exp_t e;
        @(posedge clk);
        if (!cur.reset_n) begin
            m_rem = 0;
            m_cnt = 0;
        end else begin
            m_cnt = m_cnt + (last_stall ? 32'd1 : 32'd0);
            if (m_rem > 0) m_rem = m_rem - 1;
            else if (cur.md_start_E && !cur.exc_flush) m_rem = cur.md_div_E ? 10 : 5;
        end
        #1;
        cur = nx;
        // The MD hazard holds a second mult/div in D, so E never sees one while busy
        if (m_rem > 0) cur.md_start_E = 1'b0;
        apply(cur);
        last_stall = ref_stall(cur, m_rem);
        e.stall = last_stall;
        e.busy  = (m_rem > 0);
        e.count = 4'(m_rem);
        e.cnt   = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("stall",     32'(bus.stall),    32'(e.stall));
            check("flush_E",   32'(bus.flush_E),  32'(e.stall));
            check("md_busy",   32'(bus.md_busy),  32'(e.busy));
            check("md_count",  32'(bus.md_count), 32'(e.count));
            check("stall_cnt", bus.stall_cnt,     e.cnt);
        end
    end

    initial begin
        cur = quiet();
        cur.reset_n = 1'b0;
        apply(cur);
        nx = cur;
        repeat (2) step();

        // Load-use, then the same load one stage later
        nx = quiet(); nx.Res_E = 3'd2; nx.A3_E = 5'd8; nx.rs_D = 5'd8; nx.tuse_rs_D = 2'd1; step();
        nx = quiet(); nx.Res_M = 3'd2; nx.A3_M = 5'd8; nx.rs_D = 5'd8; nx.tuse_rs_D = 2'd1; step();

        // Branch after ALU, with $0 and with a PC-sourced producer
        nx = quiet(); nx.Res_E = 3'd1; nx.A3_E = 5'd5; nx.rt_D = 5'd5; nx.tuse_rt_D = 2'd0; step();
        nx.rt_D = 5'd0; step();
        nx.rt_D = 5'd5; nx.Res_E = 3'd3; step();
        nx.Res_E = 3'd4; step();

        // mult then mflo
        nx = quiet(); nx.md_start_E = 1'b1; nx.md_use_D = 1'b1; step();
        nx.md_start_E = 1'b0;
        repeat (6) step();
        nx = quiet(); step();

        // div suppressed by exc_flush, then a real div
        nx = quiet(); nx.md_start_E = 1'b1; nx.md_div_E = 1'b1; nx.exc_flush = 1'b1; step();
        nx = quiet(); step();
        nx.md_start_E = 1'b1; nx.md_div_E = 1'b1; step();
        nx = quiet();
        nx.exc_flush = 1'b1; step();
        nx.exc_flush = 1'b0;
        repeat (11) step();

        // eret after mtc0 EPC, then with the CP0 flush
        nx = quiet(); nx.eret_D = 1'b1; nx.epc_wr_E = 1'b1; step();
        nx.exc_flush = 1'b1; step();

        // Reset in the middle of a div, with a hazard present
        nx = quiet(); nx.md_start_E = 1'b1; nx.md_div_E = 1'b1; step();
        nx = quiet();
        for (int k = 0; k < 20 && m_rem != 7; k++) step();
        nx.reset_n = 1'b0; nx.eret_D = 1'b1; nx.epc_wr_E = 1'b1; nx.md_use_D = 1'b1;
        repeat (2) step();
        nx = quiet(); step();

        // Randomized traffic over a small register window to provoke collisions
        for (int n = 0; n < 2000; n++) begin
            nx.reset_n    = ($urandom_range(0, 79) != 0);
            nx.rs_D       = 5'($urandom_range(0, 3));
            nx.rt_D       = 5'($urandom_range(0, 3));
            nx.A3_E       = 5'($urandom_range(0, 3));
            nx.A3_M       = 5'($urandom_range(0, 3));
            nx.tuse_rs_D  = 2'($urandom_range(0, 3));
            nx.tuse_rt_D  = 2'($urandom_range(0, 3));
            nx.Res_E      = 3'($urandom_range(0, 4));
            nx.Res_M      = 3'($urandom_range(0, 4));
            nx.md_use_D   = ($urandom_range(0, 3) == 0);
            nx.md_start_E = ($urandom_range(0, 5) == 0);
            nx.md_div_E   = 1'($urandom_range(0, 1));
            nx.eret_D     = ($urandom_range(0, 7) == 0);
            nx.epc_wr_E   = ($urandom_range(0, 3) == 0);
            nx.exc_flush  = ($urandom_range(0, 15) == 0);
            step();
        end

        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/stall_unit.md
Name: stall_unit

Overview:
- Hazard-detection counterpart of the pipeline forwarding logic. It asserts a stall wherever forwarding cannot deliver a value in time.
- Tracks the multi-cycle HI/LO mult/div unit with an internal countdown FSM.
- Drives PC/IF-ID freeze and the ID/EX bubble in the 5-stage MIPS core.
- Result-source codes are shared with forwarding: NW=0, ALU=1, DM=2, PC=3, MOVZ=4.

Parameters:
- MULT_CYCLES, 5, busy cycles after mult/multu leaves E.
- DIV_CYCLES, 10, busy cycles after div/divu leaves E.
- CNT_W, 4, width of the mult/div countdown; must hold DIV_CYCLES.

Ports:
- clk  in  1  pipeline clock.
- reset_n  in  1  synchronous active-low reset.
- rs_D  in  5  rs field of the instruction in D.
- rt_D  in  5  rt field of the instruction in D.
- tuse_rs_D  in  2  cycles until the D instruction needs rs (0 = branch/jr in D, 1 = ALU in E, 2 = store data in M, 3 = unused).
- tuse_rt_D  in  2  same as tuse_rs_D, for rt.
- A3_E  in  5  destination register of the E instruction.
- A3_M  in  5  destination register of the M instruction.
- Res_E  in  3  result source of the E instruction.
- Res_M  in  3  result source of the M instruction.
- md_use_D  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- md_start_E  in  1  mult/div instruction valid in E this cycle.
- md_div_E  in  1  1 = div-type, 0 = mult-type; qualified by md_start_E.
- eret_D  in  1  eret in D.
- epc_wr_E  in  1  mtc0 targeting EPC (CP0 reg 14) in E.
- exc_flush  in  1  CP0 exception/interrupt flush this cycle.
- stall  out  1  freeze PC and IF/ID.
- flush_E  out  1  load a bubble into ID/EX.
- md_busy  out  1  HI/LO unit busy.
- md_count  out  CNT_W  remaining busy cycles.
- stall_cnt  out  32  performance counter of stall cycles.

Behaviour:
- Reset, synchronous on a clk edge with reset_n=0:
  - md_count=0, FSM=IDLE, stall_cnt=0.
  - stall and flush_E are combinationally forced to 0 while reset_n=0.
- Tnew of the E instruction: ALU→1, MOVZ→1, DM→2, PC→0, NW→none.
- Tnew of the M instruction: DM→1, anything else→0/none.
- Register hazard on rs: rs_D≠0 && A3_E==rs_D && Tnew_E>tuse_rs_D, or rs_D≠0 && A3_M==rs_D && Tnew_M>tuse_rs_D. The same rule applies to rt. Tnew=0 never stalls, because forwarding covers it.
- MD hazard: md_use_D && (md_busy || md_start_E).
- EPC hazard: eret_D && epc_wr_E. The M-stage case is handled by forwarding.
- stall = any hazard. flush_E = stall. Both are combinational, with zero latency.
- exc_flush overrides everything: stall=0, flush_E=0. The CP0 flush owns the pipeline that cycle.
- MD FSM states: IDLE and BUSY.
  - IDLE→BUSY when md_start_E && !exc_flush. Load md_count = MULT_CYCLES or DIV_CYCLES.
  - In BUSY, md_count decrements by 1 each cycle. At count 1→0 the FSM returns to IDLE.
  - md_start_E while BUSY cannot occur, because the MD hazard keeps it in D. If it does occur anyway, ignore it (assertion in bench).
- md_busy = (state==BUSY). It is registered; md_start_E is covered by the hazard term above.
- exc_flush with md_start_E: the start is suppressed and the count is not loaded.
- exc_flush while BUSY: the count continues. The operation completes; HI/LO is architecturally committed.
- stall_cnt increments on every cycle with stall=1 and wraps at 2^32.
- Reset mid-BUSY: the next edge forces IDLE with md_count=0.

Decomposition:
- Shared package/header holds:
  - Res codes NW/ALU/DM/PC/MOVZ.
  - Tuse encodings.
  - EPC register index 14.
  - Tnew lookup function.
- One sub-module, md_busy_ctr: the FSM plus countdown, parameterised by MULT_CYCLES/DIV_CYCLES.
- The hazard compare stays in stall_unit.

Test Plan:
- Load-use: Res_E=DM, A3_E=8, rs_D=8, tuse_rs_D=1 → stall=1 and flush_E=1 for 1 cycle. Next cycle Res_M=DM, Tnew_M=1, tuse=1 → stall=0.
- Branch after ALU: Res_E=ALU, A3_E=5, rt_D=5, tuse_rt_D=0 → stall=1. Same case with rt_D=0 → stall=0. Same case with Res_E=PC → stall=0.
- mult then mflo: md_start_E=1, md_div_E=0 → md_busy=1 next edge, md_count=5,4,3,2,1. With md_use_D=1, stall holds for 6 cycles in total, then releases once md_count=0. stall_cnt=6.
- div with exc_flush in the same cycle → no load, md_busy stays 0. An unflushed div gives 10 busy cycles.
- eret_D=1 with epc_wr_E=1 → stall=1. With exc_flush=1 as well → stall=0.
- reset_n=0 at md_count=7 → after the edge, md_count=0, md_busy=0, stall_cnt=0, and stall=0 throughout reset.
